// File: rtl/qdrii_read_cal_if.sv
// qdrii_read_cal_if
//   Memory-side bus between the read-capture calibration sequencer and the
//   QDRII command/read path.
//
//   Handshake: a command is transferred on every clk0 edge where cmd_valid and
//   cmd_ready are both high. Once cmd_valid rises, the sender holds cmd_valid,
//   cmd_wr, cmd_addr and cmd_wdata stable until that transfer edge. cmd_ready
//   may toggle freely and carries no meaning while cmd_valid is low. Read
//   beats have no back-pressure: rd_valid qualifies rd_data for one cycle, and
//   the two beats of a burst come on consecutive cycles.
//
//   Signals:
//     cmd_valid  master->slave  command request
//     cmd_ready  slave->master  command accepted when cmd_valid & cmd_ready
//     cmd_wr     master->slave  1 = write, 0 = read (2-beat burst)
//     cmd_addr   master->slave  command address
//     cmd_wdata  master->slave  write burst as {beat1, beat0}
//     rd_valid   slave->master  read beat valid
//     rd_data    slave->master  read beat
interface qdrii_read_cal_if #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 19
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_wr;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [2*DATA_WIDTH-1:0] cmd_wdata;
    logic                    rd_valid;
    logic [DATA_WIDTH-1:0]   rd_data;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        input  cmd_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        output cmd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/qdrii_read_cal.sv
// qdrii_read_cal
//   Post-reset QDRII read-capture calibration sequencer (clk0 domain).
//   After the memory power-up interval it writes a training burst {P1, P0},
//   then sweeps the read-data IDELAY tap upward from 0, reading the burst back
//   at each tap. The first contiguous run of passing taps is the window; the
//   tap is then reset and stepped to the window centre and cal_done is raised.
//   A missing or too-narrow window raises cal_fail. Until one of those, the
//   sequencer owns the memory command port.
//
//   Ports:
//     clk0        sole clock
//     user_rst_0  synchronous, active-high reset (restarts everything)
//     mem         command/read bus (master side)
//     dly_rst     one-cycle pulse: IDELAY back to tap 0
//     dly_ce      one-cycle pulse: IDELAY one tap step
//     dly_inc     step direction, high together with dly_ce
//     cal_tap     tap the IDELAY is believed to sit at
//     cal_done    calibration passed (sticky until reset)
//     cal_fail    calibration failed (sticky until reset)
//     state_dbg   current FSM state encoding
module qdrii_read_cal #(
    parameter int PWRUP_CYCLES  = 40000,
    parameter int DATA_WIDTH    = 36,
    parameter int ADDR_WIDTH    = 19,
    parameter int CAL_ADDR      = 0,
    parameter int MAX_TAP       = 63,
    parameter int SETTLE_CYCLES = 8,
    parameter int RD_TIMEOUT    = 32,
    parameter int MIN_WINDOW    = 4
) (
    input  logic             clk0,
    input  logic             user_rst_0,
    qdrii_read_cal_if.master mem,
    output logic             dly_rst,
    output logic             dly_ce,
    output logic             dly_inc,
    output logic [5:0]       cal_tap,
    output logic             cal_done,
    output logic             cal_fail,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_DRST, S_WR, S_SETTLE, S_RD, S_RWAIT, S_EVAL,
        S_STEP, S_DECIDE, S_CRST, S_CSTEP, S_CWAIT, S_DONE, S_FAIL
    } state_t;

    // Alternating pattern, bit i = ~i[0] (bit 0 is 1).
    function automatic logic [DATA_WIDTH-1:0] alt_pattern();
        logic [DATA_WIDTH-1:0] p;
        for (int i = 0; i < DATA_WIDTH; i++) p[i] = (i % 2 == 0);
        return p;
    endfunction

    localparam logic [DATA_WIDTH-1:0] P0           = alt_pattern();
    localparam logic [DATA_WIDTH-1:0] P1           = ~P0;
    localparam logic [ADDR_WIDTH-1:0] CAL_ADDR_W   = ADDR_WIDTH'(CAL_ADDR);
    localparam logic [5:0]            MAX_TAP_W    = 6'(MAX_TAP);
    localparam logic [6:0]            MIN_WINDOW_W = 7'(MIN_WINDOW);
    localparam logic [31:0]           PWRUP_LAST   = 32'(PWRUP_CYCLES - 1);
    localparam logic [31:0]           SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]           TIMEOUT_LAST = 32'(RD_TIMEOUT - 1);

    state_t      state, state_n;
    logic [31:0] cnt;          // cycles spent in the current state
    logic        got0;         // beat 0 of the current read has arrived
    logic        beat0_ok;     // beat 0 matched P0
    logic        rd_pass;      // result of the last read, consumed in EVAL
    logic        seen;         // at least one passing tap so far
    logic        closed;       // a fail has followed a pass
    logic [5:0]  first_good;
    logic [5:0]  last_good;
    logic [5:0]  centre;

    logic        closed_now;
    logic [5:0]  span;
    logic [5:0]  centre_calc;
    logic        window_ok;

    // Window closes on the first fail after any pass, including this EVAL.
    assign closed_now  = closed | (seen & ~rd_pass);
    assign span        = last_good - first_good;
    assign centre_calc = first_good + (span >> 1);
    // Width is computed in 7 bits so a full 0..63 window does not wrap to 0.
    assign window_ok   = seen && (({1'b0, span} + 7'd1) >= MIN_WINDOW_W);

    always_ff @(posedge clk0) begin
        if (user_rst_0) state <= S_IDLE;
        else            state <= state_n;
    end

    always_ff @(posedge clk0) begin
        if (user_rst_0) begin
            cnt        <= '0;
            cal_tap    <= '0;
            got0       <= 1'b0;
            beat0_ok   <= 1'b0;
            rd_pass    <= 1'b0;
            seen       <= 1'b0;
            closed     <= 1'b0;
            first_good <= '0;
            last_good  <= '0;
            centre     <= '0;
        end else begin
            // cnt restarts at 0 on every state change, so in RWAIT it counts
            // from the cycle after read acceptance.
            cnt <= (state_n != state) ? 32'd0 : cnt + 32'd1;
            case (state)
                S_DRST: begin
                    cal_tap    <= '0;
                    seen       <= 1'b0;
                    closed     <= 1'b0;
                    first_good <= '0;
                    last_good  <= '0;
                end
                S_RD: begin
                    got0     <= 1'b0;
                    beat0_ok <= 1'b0;
                    rd_pass  <= 1'b0;
                end
                S_RWAIT: begin
                    if (!got0) begin
                        if (mem.rd_valid) begin
                            got0     <= 1'b1;
                            beat0_ok <= (mem.rd_data == P0);
                        end
                    end else begin
                        // Beat 1 must follow on the very next cycle; a gap
                        // leaves rd_valid low here and fails the tap.
                        rd_pass <= beat0_ok && mem.rd_valid && (mem.rd_data == P1);
                    end
                end
                S_EVAL: begin
                    if (rd_pass) begin
                        if (!seen) first_good <= cal_tap;
                        seen      <= 1'b1;
                        last_good <= cal_tap;
                    end else if (seen) begin
                        closed <= 1'b1;
                    end
                end
                S_STEP, S_CSTEP: cal_tap <= cal_tap + 6'd1;
                S_DECIDE:        centre  <= centre_calc;
                S_CRST:          cal_tap <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n       = state;
        mem.cmd_valid = 1'b0;
        mem.cmd_wr    = 1'b0;
        mem.cmd_addr  = '0;
        mem.cmd_wdata = '0;
        dly_rst       = 1'b0;
        dly_ce        = 1'b0;
        dly_inc       = 1'b0;
        case (state)
            S_IDLE:  state_n = S_PWRUP;
            S_PWRUP: if (cnt == PWRUP_LAST) state_n = S_DRST;
            S_DRST: begin
                dly_rst = 1'b1;
                state_n = S_WR;
            end
            S_WR: begin
                mem.cmd_valid = 1'b1;
                mem.cmd_wr    = 1'b1;
                mem.cmd_addr  = CAL_ADDR_W;
                mem.cmd_wdata = {P1, P0};
                if (mem.cmd_ready) state_n = S_SETTLE;
            end
            S_SETTLE: if (cnt == SETTLE_LAST) state_n = S_RD;
            S_RD: begin
                mem.cmd_valid = 1'b1;
                mem.cmd_addr  = CAL_ADDR_W;
                if (mem.cmd_ready) state_n = S_RWAIT;
            end
            S_RWAIT: begin
                // Beat 0 may arrive on any of the first RD_TIMEOUT cycles.
                if (got0) state_n = S_EVAL;
                else if (!mem.rd_valid && cnt == TIMEOUT_LAST) state_n = S_EVAL;
            end
            S_EVAL: begin
                if (closed_now || cal_tap == MAX_TAP_W) state_n = S_DECIDE;
                else                                     state_n = S_STEP;
            end
            S_STEP: begin
                dly_ce  = 1'b1;
                dly_inc = 1'b1;
                state_n = S_SETTLE;
            end
            S_DECIDE: state_n = window_ok ? S_CRST : S_FAIL;
            S_CRST: begin
                dly_rst = 1'b1;
                state_n = (centre == 6'd0) ? S_DONE : S_CSTEP;
            end
            S_CSTEP: begin
                dly_ce  = 1'b1;
                dly_inc = 1'b1;
                state_n = S_CWAIT;
            end
            S_CWAIT: begin
                if (cnt == SETTLE_LAST) state_n = (cal_tap == centre) ? S_DONE : S_CSTEP;
            end
            S_DONE:  state_n = S_DONE;
            S_FAIL:  state_n = S_FAIL;
            default: state_n = S_IDLE;
        endcase
    end

    assign cal_done  = (state == S_DONE);
    assign cal_fail  = (state == S_FAIL);
    assign state_dbg = state;

endmodule
